// File: rtl/throw_timer.sv
// Per-throw countdown timer: counts down START_SECS on one-second ticks, drives
// two active-low 7-segment digits, and flags timeout / tick-generator restart.
module throw_timer #(
    parameter int START_SECS = 10
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       start,
    input  logic       pause,
    input  logic       throw_done,
    output logic [5:0] secs_left,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic       running,
    output logic       timeout,
    output logic       tick_restart
);

    localparam logic [5:0] START_V = 6'(START_SECS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_EXPIRED = 3'd4
    } state_t;

    state_t     state_r;
    logic [5:0] secs_r;
    logic       running_r;
    logic       timeout_r;
    logic       tick_restart_r;
    logic [3:0] tens_s;
    logic [3:0] ones_s;
    logic [5:0] ones_wide_s;

    // Tens digit of a 0..59 value by range compare, avoiding a divider.
    function automatic logic [3:0] tens_of(input logic [5:0] v);
        logic [3:0] t;
        if (v >= 6'd50) begin
            t = 4'd5;
        end else if (v >= 6'd40) begin
            t = 4'd4;
        end else if (v >= 6'd30) begin
            t = 4'd3;
        end else if (v >= 6'd20) begin
            t = 4'd2;
        end else if (v >= 6'd10) begin
            t = 4'd1;
        end else begin
            t = 4'd0;
        end
        return t;
    endfunction

    // Active-low segment pattern, bit6..bit0 = g..a; non-digits blank.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Countdown state machine; start overrides every other event in the cycle.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            secs_r         <= START_V;
            running_r      <= 1'b0;
            timeout_r      <= 1'b0;
            tick_restart_r <= 1'b0;
        end else begin
            timeout_r      <= 1'b0;
            tick_restart_r <= 1'b0;
            if (start) begin
                state_r        <= ST_RUN;
                secs_r         <= START_V;
                running_r      <= 1'b1;
                tick_restart_r <= 1'b1;
            end else begin
                case (state_r)
                    ST_RUN: begin
                        if (throw_done) begin
                            state_r   <= ST_HOLD;
                            running_r <= 1'b0;
                        end else if (pause) begin
                            state_r   <= ST_PAUSE;
                            running_r <= 1'b0;
                        end else if (sec_tick) begin
                            if (secs_r > 6'd1) begin
                                secs_r <= secs_r - 6'd1;
                            end else begin
                                secs_r    <= 6'd0;
                                state_r   <= ST_EXPIRED;
                                running_r <= 1'b0;
                                timeout_r <= 1'b1;
                            end
                        end else begin
                            secs_r <= secs_r;
                        end
                    end
                    ST_PAUSE: begin
                        if (throw_done) begin
                            state_r <= ST_HOLD;
                        end else if (!pause) begin
                            // Resume keeps the partial second; no tick restart.
                            state_r   <= ST_RUN;
                            running_r <= 1'b1;
                        end else begin
                            state_r <= ST_PAUSE;
                        end
                    end
                    ST_IDLE, ST_HOLD, ST_EXPIRED: begin
                        state_r <= state_r;
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        secs_r    <= START_V;
                        running_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // BCD split and segment decode of the registered count.
    always_comb begin
        tens_s      = tens_of(secs_r);
        ones_wide_s = secs_r - (6'(tens_s) * 6'd10);
        ones_s      = ones_wide_s[3:0];
    end

    assign secs_left    = secs_r;
    assign HEX1         = seg_of(tens_s);
    assign HEX0         = seg_of(ones_s);
    assign running      = running_r;
    assign timeout      = timeout_r;
    assign tick_restart = tick_restart_r;

endmodule

// File: doc/throw_timer.md
# throw_timer

Per-throw countdown timer for the bowling game. Consumes the one-cycle-per-second `enable` pulse from the one-second tick generator and counts down the time a player has to throw. Reports the remaining seconds in binary and on two active-low 7-segment digits. Signals the game FSM on timeout, and emits a restart pulse so the tick generator begins a full second whenever a countdown is (re)loaded.

## Interface
- `START_SECS`, default 10: seconds loaded at reset and on every start. Legal range 1..59.
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `sec_tick`  in  1  one-cycle pulse once per second, taken from the tick generator's `enable`.
- `start`  in  1  one-cycle request from the game FSM: load `START_SECS` and run.
- `pause`  in  1  level; while high, countdown is frozen.
- `throw_done`  in  1  one-cycle pulse when a throw is detected; freezes the remaining time.
- `secs_left`  out  6  remaining seconds, unsigned binary, registered.
- `HEX1`  out  7  tens digit of `secs_left`; active-low; bit6..bit0 = g..a.
- `HEX0`  out  7  ones digit of `secs_left`; same encoding.
- `running`  out  1  high in RUN only.
- `timeout`  out  1  one-cycle pulse when the countdown reaches 0.
- `tick_restart`  out  1  one-cycle pulse; top level inverts it onto the tick generator's active-low `KEY`.

## Operation
- States: IDLE, RUN, PAUSE, HOLD, EXPIRED. All are registered.
- Event priority within a cycle: `start` > `throw_done` > `pause` > `sec_tick`. Lower-priority events in the same cycle are dropped, not deferred.
- `start` in any state, including RUN and PAUSE:
  - `secs_left` <= `START_SECS`.
  - State <= RUN, even if `pause` is high.
  - `tick_restart` pulses.
- IDLE:
  - `secs_left` = `START_SECS`.
  - `sec_tick`, `pause` and `throw_done` are ignored.
- RUN:
  - `throw_done` -> HOLD.
  - Else `pause` high -> PAUSE.
  - Else `sec_tick` with `secs_left` > 1 -> decrement by 1.
  - Else `sec_tick` with `secs_left` == 1 -> `secs_left` <= 0, state <= EXPIRED, `timeout` pulses.
- PAUSE:
  - `throw_done` -> HOLD.
  - `pause` low -> RUN.
  - `sec_tick` is ignored.
  - No `tick_restart` on resume; the partial second continues.
- HOLD: `secs_left` frozen; exits only on `start`.
- EXPIRED: `secs_left` = 0; exits only on `start`.
- `secs_left` never underflows and never exceeds `START_SECS`.
- BCD conversion: tens = `secs_left` / 10 (0..5), ones = `secs_left` mod 10.
- Segment codes for 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Tens digit at 0 is displayed as 0, not blanked.

## Timing
- Values on reset assertion, asynchronously:
  - state = IDLE.
  - `secs_left` = `START_SECS`.
  - `running` = 0, `timeout` = 0, `tick_restart` = 0.
  - `HEX1`/`HEX0` show `START_SECS`; with START_SECS=10 that is 1111001 / 1000000.
- Reset deassertion: the first active edge may carry `start`, which is honoured.
- Latency: every input event is sampled on a `CLOCK_50` rising edge. `secs_left`, `running`, `timeout` and `tick_restart` update on that same edge, one cycle after the input is presented.
- HEX outputs are combinational decodes of registered `secs_left`; they change in the same cycle as `secs_left`.
- `timeout` is high for exactly one cycle: the cycle in which `secs_left` first reads 0. It is never re-asserted while in EXPIRED.
- `tick_restart` is high for exactly one cycle per accepted `start`. Back-to-back `start` pulses produce back-to-back restart pulses.
- Reset mid-countdown aborts immediately. No `timeout` is produced.

## Test plan
- Reset, START_SECS=10 -> `secs_left`=10, HEX1=1111001, HEX0=1000000, `running`=0, `timeout`=0.
- START_SECS=3: `start`, then 3 `sec_tick` pulses 5 cycles apart:
  - `tick_restart` is one pulse, the cycle after `start`.
  - `secs_left` goes 3,2,1,0.
  - `timeout` is a single pulse coinciding with 0; state EXPIRED; further ticks leave 0.
- START_SECS=3: run, then `pause` high with 2 ticks, then `pause` low and 1 tick:
  - `secs_left` holds at 3 while paused, then reads 2.
  - No `tick_restart` on resume.
- `throw_done` and `sec_tick` in the same cycle at `secs_left`=2 -> HOLD with `secs_left`=2; later ticks ignored; `running`=0.
- `start` in the same cycle as the tick reaching 1->0 -> reload to `START_SECS`, RUN, no `timeout`, one `tick_restart`.
- Async reset asserted mid-RUN between clock edges -> outputs return to reset values without waiting for a clock edge.
